// File: rtl/hack_cpu_ctrl_if.sv
// Bus bundle between the Hack control unit and its ROM, data memory and external ALU.
// master = control unit side, slave = memory/ALU side.
interface hack_cpu_ctrl_if;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic        rom_ack;
  logic [15:0] rom_data;

  logic        mem_rd;
  logic        mem_wr;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_zx;
  logic        alu_nx;
  logic        alu_zy;
  logic        alu_ny;
  logic        alu_f;
  logic        alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;

  modport master (
    output rom_req, rom_addr,
    input  rom_ack, rom_data,
    output mem_rd, mem_wr, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    input  alu_out, alu_zr, alu_ng
  );

  modport slave (
    input  rom_req, rom_addr,
    output rom_ack, rom_data,
    input  mem_rd, mem_wr, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  alu_x, alu_y, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no,
    output alu_out, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control unit: fetch, decode, optional M read, execute on an
// external ALU, optional M write. Request outputs are registered alongside the state.
module hack_cpu_ctrl (
  input  logic                  clk,
  input  logic                  reset,
  hack_cpu_ctrl_if.master       bus,
  output logic [14:0]           pc
);

  typedef enum logic [2:0] {
    START  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEMRD  = 3'd3,
    EXEC   = 3'd4,
    MEMWR  = 3'd5
  } state_t;

  state_t      state_reg;
  logic [15:0] ir_reg;
  logic [15:0] a_reg;
  logic [15:0] d_reg;
  logic [15:0] m_reg;
  logic [14:0] mar_reg;
  logic [15:0] r_reg;
  logic [14:0] pc_reg;
  logic        rom_req_reg;
  logic        mem_rd_reg;
  logic        mem_wr_reg;

  logic [14:0] pc_inc;
  logic        jump_taken;
  logic        unused_ir_bits;

  assign pc_inc     = pc_reg + 15'd1;
  assign jump_taken = (ir_reg[2] & bus.alu_ng)
                    | (ir_reg[1] & bus.alu_zr)
                    | (ir_reg[0] & ~bus.alu_zr & ~bus.alu_ng);
  assign unused_ir_bits = ^ir_reg[14:13];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= START;
      ir_reg      <= '0;
      a_reg       <= '0;
      d_reg       <= '0;
      m_reg       <= '0;
      mar_reg     <= '0;
      r_reg       <= '0;
      pc_reg      <= '0;
      rom_req_reg <= 1'b0;
      mem_rd_reg  <= 1'b0;
      mem_wr_reg  <= 1'b0;
    end else begin
      case (state_reg)
        START: begin
          state_reg   <= FETCH;
          rom_req_reg <= 1'b1;
        end
        FETCH: begin
          if (bus.rom_ack) begin
            ir_reg      <= bus.rom_data;
            state_reg   <= DECODE;
            rom_req_reg <= 1'b0;
          end
        end
        DECODE: begin
          // MAR captures the address before EXEC can overwrite A.
          mar_reg <= a_reg[14:0];
          if (!ir_reg[15]) begin
            a_reg       <= ir_reg;
            pc_reg      <= pc_inc;
            state_reg   <= FETCH;
            rom_req_reg <= 1'b1;
          end else if (ir_reg[12]) begin
            state_reg  <= MEMRD;
            mem_rd_reg <= 1'b1;
          end else begin
            state_reg <= EXEC;
          end
        end
        MEMRD: begin
          if (bus.mem_ack) begin
            m_reg      <= bus.mem_rdata;
            state_reg  <= EXEC;
            mem_rd_reg <= 1'b0;
          end
        end
        EXEC: begin
          r_reg <= bus.alu_out;
          if (ir_reg[4]) d_reg <= bus.alu_out;
          if (ir_reg[5]) a_reg <= bus.alu_out;
          pc_reg <= jump_taken ? a_reg[14:0] : pc_inc;
          if (ir_reg[3]) begin
            state_reg  <= MEMWR;
            mem_wr_reg <= 1'b1;
          end else begin
            state_reg   <= FETCH;
            rom_req_reg <= 1'b1;
          end
        end
        MEMWR: begin
          if (bus.mem_ack) begin
            state_reg   <= FETCH;
            mem_wr_reg  <= 1'b0;
            rom_req_reg <= 1'b1;
          end
        end
        default: begin
          state_reg   <= START;
          rom_req_reg <= 1'b0;
          mem_rd_reg  <= 1'b0;
          mem_wr_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rom_req   = rom_req_reg;
  assign bus.rom_addr  = pc_reg;
  assign bus.mem_rd    = mem_rd_reg;
  assign bus.mem_wr    = mem_wr_reg;
  assign bus.mem_addr  = mar_reg;
  assign bus.mem_wdata = r_reg;

  assign bus.alu_x  = d_reg;
  assign bus.alu_y  = ir_reg[12] ? m_reg : a_reg;
  assign bus.alu_zx = ir_reg[11];
  assign bus.alu_nx = ir_reg[10];
  assign bus.alu_zy = ir_reg[9];
  assign bus.alu_ny = ir_reg[8];
  assign bus.alu_f  = ir_reg[7];
  assign bus.alu_no = ir_reg[6];

  assign pc = pc_reg;

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: drives ROM/memory handshakes with random wait states, supplies the
// Hack ALU, and compares against an instruction-level model of A, D, PC and memory traffic.
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] pc;

  int total = 0;
  int bad   = 0;

  logic [15:0] a_m = '0;
  logic [15:0] d_m = '0;
  logic [14:0] pc_m = '0;

  hack_cpu_ctrl_if bus ();

  hack_cpu_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .pc    (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_fn(input logic [15:0] x, input logic [15:0] y,
                                         input logic [5:0] c);
    logic [15:0] xv, yv, o;
    xv = c[5] ? 16'h0000 : x;
    xv = c[4] ? ~xv : xv;
    yv = c[3] ? 16'h0000 : y;
    yv = c[2] ? ~yv : yv;
    o  = c[1] ? xv + yv : xv & yv;
    return c[0] ? ~o : o;
  endfunction

  assign bus.alu_out = alu_fn(bus.alu_x, bus.alu_y,
                              {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no});
  assign bus.alu_zr  = (bus.alu_out == 16'h0000);
  assign bus.alu_ng  = bus.alu_out[15];

  task automatic do_reset();
    bus.rom_ack = 1'b0;
    bus.mem_ack = 1'b0;
    bus.rom_data = '0;
    bus.mem_rdata = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.rom_req, bus.mem_rd, bus.mem_wr} !== 3'b000 || pc !== 15'd0 ||
        bus.alu_x !== 16'd0 || bus.alu_y !== 16'd0 ||
        {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} !== 6'd0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b rd=%b wr=%b pc=%h x=%h y=%h, want all zero",
               bus.rom_req, bus.mem_rd, bus.mem_wr, pc, bus.alu_x, bus.alu_y);
    end
    reset = 1'b0;
    total++;
    if (bus.rom_req !== 1'b0) begin
      bad++;
      $display("FAIL start_idle: rom_req=%b want 0", bus.rom_req);
    end
    @(posedge clk);
    @(negedge clk);
    total++;
    if (bus.rom_req !== 1'b1 || bus.rom_addr !== 15'd0 || pc !== 15'd0) begin
      bad++;
      $display("FAIL first_fetch: rom_req=%b rom_addr=%h pc=%h want 1/0000/0000",
               bus.rom_req, bus.rom_addr, pc);
    end
    a_m  = '0;
    d_m  = '0;
    pc_m = '0;
    $display("reset: released, first fetch at pc=%h", pc);
  endtask

  // Runs one instruction from its fetch to the next fetch; expects to start at a negedge in FETCH.
  task automatic run_instr(input logic [15:0] instr, input int rom_wait, input int mem_wait,
                           input logic [15:0] mdata, input bit abort_wr, input string tag);
    logic [15:0] y_v, o_v, a_n, d_n, wdata_seen;
    logic [14:0] pc_n, waddr_seen, raddr_seen;
    bit rd_e, wr_e, jmp, fetched, dec_chk, done;
    int cyc_e, cyc, rw, mrw, mww, rd_cnt, wr_cnt;
    fetched = 0; dec_chk = 0; done = 0;
    rw = 0; mrw = 0; mww = 0; rd_cnt = 0; wr_cnt = 0;
    wdata_seen = '0; waddr_seen = '0; raddr_seen = '0;
    o_v = '0;

    if (!instr[15]) begin
      a_n = instr; d_n = d_m; pc_n = pc_m + 15'd1;
      rd_e = 0; wr_e = 0;
      cyc_e = 2 + rom_wait;
    end else begin
      y_v = instr[12] ? mdata : a_m;
      o_v = alu_fn(d_m, y_v, instr[11:6]);
      jmp = (instr[2] && $signed(o_v) < 0) || (instr[1] && o_v == 16'd0) ||
            (instr[0] && $signed(o_v) > 0);
      d_n = instr[4] ? o_v : d_m;
      a_n = instr[5] ? o_v : a_m;
      pc_n = jmp ? a_m[14:0] : pc_m + 15'd1;
      rd_e = instr[12];
      wr_e = instr[3];
      cyc_e = 3 + rom_wait + (rd_e ? mem_wait + 1 : 0) + (wr_e ? mem_wait + 1 : 0);
    end

    for (cyc = 0; cyc < 80; cyc++) begin
      bus.rom_ack = 1'b0;
      bus.mem_ack = 1'b0;
      if (bus.rom_req && fetched) begin
        done = 1;
        break;
      end
      total++;
      if (int'(bus.rom_req) + int'(bus.mem_rd) + int'(bus.mem_wr) > 1) begin
        bad++;
        $display("FAIL %s exclusive_req: req=%b rd=%b wr=%b", tag, bus.rom_req, bus.mem_rd, bus.mem_wr);
      end
      if (bus.rom_req) begin
        if (rw == 0) begin
          total++;
          if (bus.rom_addr !== pc_m || pc !== pc_m) begin
            bad++;
            $display("FAIL %s fetch_addr: rom_addr=%h pc=%h want %h", tag, bus.rom_addr, pc, pc_m);
          end
        end
        if (rw == rom_wait) begin
          bus.rom_ack = 1'b1;
          bus.rom_data = instr;
          fetched = 1;
        end else begin
          rw++;
          bus.mem_ack = 1'($urandom_range(0, 1));
        end
      end else if (fetched && !dec_chk) begin
        dec_chk = 1;
        total++;
        if ({bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no} !== instr[11:6] ||
            bus.alu_x !== d_m || (!instr[12] && bus.alu_y !== a_m)) begin
          bad++;
          $display("FAIL %s decode_alu: ctl=%b x=%h y=%h want ctl=%b x=%h y(A)=%h", tag,
                   {bus.alu_zx, bus.alu_nx, bus.alu_zy, bus.alu_ny, bus.alu_f, bus.alu_no},
                   bus.alu_x, bus.alu_y, instr[11:6], d_m, a_m);
        end
      end
      if (bus.mem_rd) begin
        rd_cnt++;
        raddr_seen = bus.mem_addr;
        if (mrw == mem_wait) begin
          bus.mem_ack = 1'b1;
          bus.mem_rdata = mdata;
        end else begin
          mrw++;
          bus.rom_ack = 1'($urandom_range(0, 1));
          bus.mem_rdata = 16'($urandom());
        end
      end
      if (bus.mem_wr) begin
        if (abort_wr) begin
          reset = 1'b1;
          #1;
          total++;
          if ({bus.rom_req, bus.mem_rd, bus.mem_wr} !== 3'b000) begin
            bad++;
            $display("FAIL %s abort_outputs: req=%b rd=%b wr=%b want 000", tag,
                     bus.rom_req, bus.mem_rd, bus.mem_wr);
          end
          total++;
          if ({dut.ir_reg, dut.a_reg, dut.d_reg, dut.m_reg, dut.r_reg, dut.mar_reg, dut.pc_reg} !== '0) begin
            bad++;
            $display("FAIL %s abort_regs: ir=%h a=%h d=%h m=%h r=%h mar=%h pc=%h want all 0", tag,
                     dut.ir_reg, dut.a_reg, dut.d_reg, dut.m_reg, dut.r_reg, dut.mar_reg, dut.pc_reg);
          end
          bus.mem_ack = 1'b0;
          bus.rom_ack = 1'b0;
          $display("%s: reset during write, registers cleared", tag);
          return;
        end
        wr_cnt++;
        waddr_seen = bus.mem_addr;
        wdata_seen = bus.mem_wdata;
        if (mww == mem_wait) bus.mem_ack = 1'b1;
        else begin
          mww++;
          bus.rom_ack = 1'($urandom_range(0, 1));
        end
      end
      @(posedge clk);
      @(negedge clk);
    end

    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: no next fetch within 80 cycles", tag);
      return;
    end
    total++;
    if (cyc !== cyc_e) begin
      bad++;
      $display("FAIL %s cycles: got %0d want %0d", tag, cyc, cyc_e);
    end
    total++;
    if (pc !== pc_n || dut.a_reg !== a_n || dut.d_reg !== d_n) begin
      bad++;
      $display("FAIL %s regs: pc=%h a=%h d=%h want pc=%h a=%h d=%h", tag,
               pc, dut.a_reg, dut.d_reg, pc_n, a_n, d_n);
    end
    total++;
    if (rd_cnt !== (rd_e ? mem_wait + 1 : 0) || (rd_e && raddr_seen !== a_m[14:0])) begin
      bad++;
      $display("FAIL %s mem_read: cycles=%0d addr=%h want cycles=%0d addr=%h", tag,
               rd_cnt, raddr_seen, rd_e ? mem_wait + 1 : 0, a_m[14:0]);
    end
    total++;
    if (wr_cnt !== (wr_e ? mem_wait + 1 : 0) ||
        (wr_e && (waddr_seen !== a_m[14:0] || wdata_seen !== o_v))) begin
      bad++;
      $display("FAIL %s mem_write: cycles=%0d addr=%h data=%h want cycles=%0d addr=%h data=%h", tag,
               wr_cnt, waddr_seen, wdata_seen, wr_e ? mem_wait + 1 : 0, a_m[14:0], o_v);
    end
    $display("%s: instr=%h cyc=%0d pc=%h a=%h d=%h rd=%0d wr=%0d", tag, instr, cyc, pc,
             dut.a_reg, dut.d_reg, rd_cnt, wr_cnt);
    a_m  = a_n;
    d_m  = d_n;
    pc_m = pc_n;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_a_then_d();
    run_instr(16'h0005, 0, 0, 16'h0, 0, "a_load5");
    run_instr(16'hEC10, 0, 0, 16'h0, 0, "d_eq_a");
    total++;
    if (pc !== 15'd2 || dut.d_reg !== 16'd5) begin
      bad++;
      $display("FAIL a_then_d: pc=%h d=%h want 0002/0005", pc, dut.d_reg);
    end
  endtask

  task automatic test_mem_write_wait();
    run_instr(16'h0005, 1, 0, 16'h0, 0, "w_a5");
    run_instr(16'hEC10, 0, 0, 16'h0, 0, "w_d_eq_a");
    run_instr(16'h0010, 0, 0, 16'h0, 0, "w_a10");
    run_instr(16'hE308, 0, 3, 16'h0, 0, "m_eq_d_wait3");
  endtask

  task automatic test_am_ordering();
    run_instr(16'h0020, 0, 0, 16'h0, 0, "am_a20");
    run_instr(16'hFDE8, 0, 1, 16'h00FF, 0, "am_eq_m_plus1");
    total++;
    if (dut.a_reg !== 16'h0100) begin
      bad++;
      $display("FAIL am_new_a: a=%h want 0100", dut.a_reg);
    end
  endtask

  task automatic test_jumps();
    run_instr(16'h0003, 0, 0, 16'h0, 0, "j_a3");
    run_instr(16'hEC10, 0, 0, 16'h0, 0, "j_d3");
    run_instr(16'h0040, 0, 0, 16'h0, 0, "j_a40");
    run_instr(16'hE301, 0, 0, 16'h0, 0, "jgt_taken");
    run_instr(16'h0000, 0, 0, 16'h0, 0, "j_a0");
    run_instr(16'hEC10, 0, 0, 16'h0, 0, "j_d0");
    run_instr(16'h0040, 0, 0, 16'h0, 0, "j_a40b");
    run_instr(16'hE301, 0, 0, 16'h0, 0, "jgt_not_taken");
    run_instr(16'hEE90, 0, 0, 16'h0, 0, "j_d_minus1");
    run_instr(16'h0040, 0, 0, 16'h0, 0, "j_a40c");
    run_instr(16'hE304, 0, 0, 16'h0, 0, "jlt_taken");
  endtask

  task automatic test_wrap();
    run_instr(16'h7FFF, 0, 0, 16'h0, 0, "wr_a7fff");
    run_instr(16'hEA87, 0, 0, 16'h0, 0, "wr_jmp");
    run_instr(16'h1234, 2, 0, 16'h0, 0, "wr_ainstr_at_top");
    total++;
    if (pc !== 15'd0) begin
      bad++;
      $display("FAIL pc_wrap: pc=%h want 0000", pc);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    for (int i = 0; i < 60; i++) begin
      ins = 16'($urandom());
      if (($urandom() & 1) != 0) ins[15] = 1'b1;
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 16'($urandom()), 0, "rand");
    end
  endtask

  task automatic test_mid_op_reset();
    run_instr(16'h0010, 0, 0, 16'h0, 0, "mr_a10");
    run_instr(16'hE308, 0, 3, 16'h0, 1, "mr_write_abort");
    do_reset();
    run_instr(16'h0007, 0, 0, 16'h0, 0, "mr_after");
  endtask

  initial begin
    bus.rom_ack = 1'b0;
    bus.mem_ack = 1'b0;
    bus.rom_data = '0;
    bus.mem_rdata = '0;
    test_reset();
    test_a_then_d();
    test_mem_write_wait();
    test_am_ordering();
    test_jumps();
    test_wrap();
    test_random();
    test_mid_op_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
